// File: rtl/tcdm_responder_stub.sv
// tcdm_responder_stub
//   Synthetic TCDM endpoint for one traffic-generator TCDM port. Every accepted request travels
//   through a fixed-latency delay line and then lands in a first-word fall-through response FIFO.
//   Requests are credit-limited: no more than FifoDepth may be outstanding, so the FIFO can never
//   overflow.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   tcdm_req_valid_i/ready_o     request handshake (ready = credit available)
//   tcdm_req_addr_i/wen_i/id_i   request fields; wdata_i is accepted but not stored
//   tcdm_resp_valid_o/ready_i    response handshake
//   tcdm_resp_rdata_o/id_o       head-of-FIFO response (zero while no response is pending)
//   num_req_o, num_resp_o        wrapping counts of accepted requests / delivered responses
module tcdm_responder_stub #(
  parameter int unsigned          IdWidth     = 10,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          Latency     = 2,
  parameter int unsigned          FifoDepth   = 4,
  parameter logic [DataWidth-1:0] DataPattern = 32'hA5A5A5A5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tcdm_req_valid_i,
  output logic                 tcdm_req_ready_o,
  input  logic [AddrWidth-1:0] tcdm_req_addr_i,
  input  logic                 tcdm_req_wen_i,
  input  logic [DataWidth-1:0] tcdm_req_wdata_i,
  input  logic [IdWidth-1:0]   tcdm_req_id_i,
  output logic                 tcdm_resp_valid_o,
  input  logic                 tcdm_resp_ready_i,
  output logic [DataWidth-1:0] tcdm_resp_rdata_o,
  output logic [IdWidth-1:0]   tcdm_resp_id_o,
  output logic [31:0]          num_req_o,
  output logic [31:0]          num_resp_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  if (Latency < 1 || FifoDepth < 1 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_param_err
    $error("tcdm_responder_stub: need Latency>=1 and FifoDepth a power of 2 >= 1");
  end

  // ---------------------------------------------------------------------------------------------
  // Handshakes and credit
  // ---------------------------------------------------------------------------------------------
  logic [CntW-1:0] r_outstanding;
  logic [CntW-1:0] w_outstanding_d;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;
  logic            w_accept;
  logic            w_resp_hs;
  logic            w_push;
  logic            w_empty;
  logic            w_full;

  assign tcdm_req_ready_o = (r_outstanding < CntW'(FifoDepth));
  assign w_accept         = tcdm_req_valid_i & tcdm_req_ready_o;
  assign w_empty          = (r_count == '0);
  assign w_full           = (r_count == CntW'(FifoDepth));
  assign w_resp_hs        = ~w_empty & tcdm_resp_ready_i;

  // Write data is not modelled; upper address bits may be dropped when AddrWidth > DataWidth.
  logic w_unused;
  assign w_unused = ^{tcdm_req_wdata_i, tcdm_req_addr_i};

  always_comb begin
    w_outstanding_d = r_outstanding;
    unique case ({w_accept, w_resp_hs})
      2'b10:   w_outstanding_d = r_outstanding + 1'b1;
      2'b01:   w_outstanding_d = r_outstanding - 1'b1;
      default: w_outstanding_d = r_outstanding;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstanding_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Fixed-latency delay line (never stalls; the credit bound makes room in the FIFO)
  // ---------------------------------------------------------------------------------------------
  logic [DataWidth-1:0] w_addr_ext;
  logic [DataWidth-1:0] w_stage0_data;

  if (AddrWidth >= DataWidth) begin : g_addr_trunc
    assign w_addr_ext = tcdm_req_addr_i[DataWidth-1:0];
  end else begin : g_addr_zext
    assign w_addr_ext = {{(DataWidth - AddrWidth){1'b0}}, tcdm_req_addr_i};
  end

  assign w_stage0_data = tcdm_req_wen_i ? '0 : (w_addr_ext ^ DataPattern);

  logic [Latency-1:0]   r_pipe_valid;
  logic [IdWidth-1:0]   r_pipe_id   [Latency];
  logic [DataWidth-1:0] r_pipe_data [Latency];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pipe_valid <= '0;
      for (int i = 0; i < Latency; i++) begin
        r_pipe_id[i]   <= '0;
        r_pipe_data[i] <= '0;
      end
    end else begin
      r_pipe_valid[0] <= w_accept;
      r_pipe_id[0]    <= tcdm_req_id_i;
      r_pipe_data[0]  <= w_stage0_data;
      for (int i = 1; i < Latency; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_id[i]    <= r_pipe_id[i-1];
        r_pipe_data[i]  <= r_pipe_data[i-1];
      end
    end
  end

  assign w_push = r_pipe_valid[Latency-1];

  // ---------------------------------------------------------------------------------------------
  // Response FIFO, first-word fall-through
  // ---------------------------------------------------------------------------------------------
  logic [IdWidth-1:0]   r_mem_id   [FifoDepth];
  logic [DataWidth-1:0] r_mem_data [FifoDepth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_resp_hs})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_resp_hs) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_d;
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]   <= r_pipe_id[Latency-1];
      r_mem_data[r_wr_ptr] <= r_pipe_data[Latency-1];
    end
  end

  assign tcdm_resp_valid_o = ~w_empty;
  assign tcdm_resp_id_o    = w_empty ? '0 : r_mem_id[r_rd_ptr];
  assign tcdm_resp_rdata_o = w_empty ? '0 : r_mem_data[r_rd_ptr];

  // ---------------------------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------------------------
  logic [31:0] r_num_req;
  logic [31:0] r_num_resp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_num_req  <= '0;
      r_num_resp <= '0;
    end else begin
      if (w_accept)  r_num_req  <= r_num_req + 32'd1;
      if (w_resp_hs) r_num_resp <= r_num_resp + 32'd1;
    end
  end

  assign num_req_o  = r_num_req;
  assign num_resp_o = r_num_resp;

  // Outstanding credit covers delay line plus FIFO, so a full FIFO never sees a push.
  assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));

endmodule
